trap_csr_unit: RTL and testbench
================================

TRAP_CSR_UNIT -- requirements
Module: trap_csr_unit

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
 clk  in  1  system clock, rising edge.
 rst  in  1  asynchronous reset, active-high.
 inst_valid  in  1  current instruction retires this cycle; 0 = stalled (e.g. MIO not ready).
 ecall  in  1  decoded ECALL.
 mret  in  1  decoded MRET.
 illegal_inst  in  1  decoded illegal opcode.
 INT  in  1  external interrupt, asynchronous level.
 csr_we  in  1  CSR write request from control.
 csr_op  in  2  01 RW, 10 RS, 11 RC, 00 none.
 csr_addr  in  12  CSR address.
 csr_wdata  in  32  rs1 value or zimm.
 pc_cur  in  32  PC of current instruction.
 pc_next  in  32  sequential/branch next PC.
 csr_rdata  out  32  old CSR value for rd.
 redirect  out  1  PC override this cycle.
 redirect_pc  out  32  override target.
 int_pend  out  1  synchronized interrupt pending.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-003 SHALL implement mstatus(0x300: MIE bit3, MPIE bit7, others read 0), mie(0x304: MEIE bit11 only), mtvec(0x305), mscratch(0x340), mepc(0x341, bits[1:0] read 0), mcause(0x342).
REQ-004 SHALL drive csr_rdata combinationally from csr_addr; unimplemented addresses read 0.
REQ-005 SHALL update CSRs at clk edge only when inst_valid=1; inst_valid=0 SHALL hold all state and force redirect=0.
REQ-006 SHALL compute write value RW=wdata, RS=old|wdata, RC=old&~wdata; csr_op=00 or csr_we=0 no write; writes to unimplemented addresses ignored.
REQ-007 SHALL prioritise per cycle: illegal_inst > ecall > interrupt > mret > CSR write; lower events suppressed.
REQ-008 Exception entry SHALL assert redirect=1, redirect_pc={mtvec[31:2],2'b00} same cycle; at edge mepc<=pc_cur, mcause<=2 (illegal) or 11 (ecall), MPIE<=MIE, MIE<=0.
REQ-009 Interrupt taken when int_pend & MIE & MEIE & inst_valid: redirect as REQ-008; mepc<=pc_next, mcause<=0x8000000B, MPIE<=MIE, MIE<=0, int_pend cleared.
REQ-010 mret SHALL assert redirect, redirect_pc=mepc; at edge MIE<=MPIE, MPIE<=1.
REQ-011 INT SHALL pass a 2-flop synchronizer plus edge register; rising edge of synchronized INT sets int_pend two edges after INT first sampled high.
REQ-012 int_pend set and clear in same cycle SHALL resolve to set (new edge not lost).
REQ-013 Pending interrupt with MIE=0 or MEIE=0 SHALL remain pending until enabled or reset.

Reset
REQ-014 rst SHALL clear all CSRs, synchronizer flops, int_pend and counters to 0; redirect=0 while rst high; reset mid-trap SHALL abandon it.

Configuration
REQ-015 With CSR_COUNTER_EN defined: mcycle(0xB00) increments every non-reset cycle, minstret(0xB02) increments on inst_valid without trap; both writable per REQ-006, a write overriding the increment that cycle.
REQ-016 Without CSR_COUNTER_EN: 0xB00/0xB02 read 0, writes ignored, no counter flops.

Structure
REQ-017 Shared package SHALL hold CSR address constants, mcause codes, csr_op encodings, mstatus bit indices.
REQ-018 Synchronizer plus edge detect SHALL be sub-module int_sync; CSR storage stays in trap_csr_unit.

Verification
REQ-019 Write mtvec=0x00000100 via RW, then ecall at pc_cur=0x40 -> redirect=1, redirect_pc=0x100; after edge mepc=0x40, mcause=11, MIE=0.
REQ-020 mstatus=0x8, mie=0x800, pulse INT -> int_pend=1 two edges later; next valid cycle with pc_next=0x84 -> mcause=0x8000000B, mepc=0x84, int_pend=0.
REQ-021 mret with mepc=0x84, MPIE=1 -> redirect_pc=0x84; after edge MIE=1, MPIE=1.
REQ-022 illegal_inst and ecall together at pc_cur=0x20 -> mcause=2, mepc=0x20; CSR write same cycle ignored.
REQ-023 RS mscratch 0x0F then RC 0x03 -> 0x0C; inst_valid=0 with ecall -> no redirect, state unchanged.
REQ-024 CSR_COUNTER_EN: mcycle reads N+10 ten cycles after reading N; without macro reads 0.

Source files
------------

// File: rtl/trap_csr_unit_pkg.sv
// trap_csr_unit_pkg: CSR addresses, mcause codes, csr_op encodings and mstatus/mie bit indices
package trap_csr_unit_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] MCAUSE_ECALL   = 32'd11;
  localparam logic [31:0] MCAUSE_MEI     = 32'h8000_000B;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;
  function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old, input logic [31:0] wdata);
    return op == CSR_RW ? wdata : op == CSR_RS ? (old | wdata) : (old & ~wdata);
  endfunction
endpackage

// File: rtl/trap_csr_unit_int_sync.sv
// int_sync: two-flop synchronizer plus edge register for the external interrupt line
// Ports: clk, rst (async, active-high), i_async (raw INT level), o_rise (one-cycle pulse on synchronized rising edge)
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);
  logic r_s1, r_s2, r_s3;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_s1, r_s2, r_s3} <= 3'b000;
    else {r_s1, r_s2, r_s3} <= {i_async, r_s1, r_s2};
  assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode CSR file with exception, interrupt and mret redirect logic
// Ports: clk, rst (async, active-high); inst_valid/ecall/mret/illegal_inst from decode; INT raw interrupt;
// csr_we/csr_op/csr_addr/csr_wdata CSR access; pc_cur/pc_next PCs; csr_rdata old CSR value;
// redirect/redirect_pc PC override; int_pend synchronized pending interrupt.
// Define CSR_COUNTER_EN to add mcycle (0xB00) and minstret (0xB02).
module trap_csr_unit
  import trap_csr_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic        ecall,
  input  logic        mret,
  input  logic        illegal_inst,
  input  logic        INT,
  input  logic        csr_we,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_next,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        int_pend
);
  logic        r_mie, r_mpie, r_meie, r_int_pend;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic        w_rise, w_exc, w_int, w_mret, w_wr;
  logic [31:0] w_wval;
`ifdef CSR_COUNTER_EN
  logic [31:0] r_mcycle, r_minstret;
`endif
  int_sync u_int_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(INT),
    .o_rise (w_rise)
  );
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = r_mie;
        csr_rdata[MSTATUS_MPIE] = r_mpie;
      end
      CSR_MIE:      csr_rdata[MIE_MEIE] = r_meie;
      CSR_MTVEC:    csr_rdata = r_mtvec;
      CSR_MSCRATCH: csr_rdata = r_mscratch;
      CSR_MEPC:     csr_rdata = {r_mepc[31:2], 2'b00};
      CSR_MCAUSE:   csr_rdata = r_mcause;
`ifdef CSR_COUNTER_EN
      CSR_MCYCLE:   csr_rdata = r_mcycle;
      CSR_MINSTRET: csr_rdata = r_minstret;
`endif
      default: ;
    endcase
  end
  // Priority chain: each event masks every lower one in the same cycle.
  assign w_exc  = inst_valid & (illegal_inst | ecall);
  assign w_int  = inst_valid & ~w_exc & r_int_pend & r_mie & r_meie;
  assign w_mret = inst_valid & mret & ~w_exc & ~w_int;
  assign w_wr   = inst_valid & csr_we & (csr_op != CSR_NONE) & ~w_exc & ~w_int & ~w_mret;
  assign w_wval = csr_apply(csr_op, csr_rdata, csr_wdata);
  assign redirect    = ~rst & (w_exc | w_int | w_mret);
  assign redirect_pc = w_mret ? {r_mepc[31:2], 2'b00} : {r_mtvec[31:2], 2'b00};
  assign int_pend    = r_int_pend;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_meie     <= 1'b0;
      r_int_pend <= 1'b0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      // A fresh edge wins over the clear from taking the previous interrupt.
      r_int_pend <= w_rise | (r_int_pend & ~w_int);
      if (w_exc | w_int) begin
        r_mepc   <= w_exc ? pc_cur : pc_next;
        r_mcause <= illegal_inst ? MCAUSE_ILLEGAL : ecall ? MCAUSE_ECALL : MCAUSE_MEI;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_wr) begin
        if (csr_addr == CSR_MSTATUS) begin
          r_mie  <= w_wval[MSTATUS_MIE];
          r_mpie <= w_wval[MSTATUS_MPIE];
        end
        if (csr_addr == CSR_MIE) r_meie <= w_wval[MIE_MEIE];
        if (csr_addr == CSR_MTVEC) r_mtvec <= w_wval;
        if (csr_addr == CSR_MSCRATCH) r_mscratch <= w_wval;
        if (csr_addr == CSR_MEPC) r_mepc <= w_wval;
        if (csr_addr == CSR_MCAUSE) r_mcause <= w_wval;
      end
    end
`ifdef CSR_COUNTER_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= (w_wr && csr_addr == CSR_MCYCLE) ? w_wval : r_mcycle + 32'd1;
      r_minstret <= (w_wr && csr_addr == CSR_MINSTRET) ? w_wval : r_minstret + 32'(inst_valid & ~w_exc & ~w_int);
    end
`endif
endmodule

// File: tb/tb_trap_csr_unit.sv
// tb_trap_csr_unit: directed self-checking bench for trap_csr_unit
module tb_trap_csr_unit;
  import trap_csr_unit_pkg::*;
  logic        clk, rst, inst_valid, ecall, mret, illegal_inst, INT, csr_we;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, pc_cur, pc_next, csr_rdata, redirect_pc;
  logic        redirect, int_pend;
  int          checks, failures;
  trap_csr_unit dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .ecall(ecall), .mret(mret),
    .illegal_inst(illegal_inst), .INT(INT), .csr_we(csr_we), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .pc_cur(pc_cur), .pc_next(pc_next),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .int_pend(int_pend)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask
  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1;
    csr_op = op;
    csr_addr = a;
    csr_wdata = d;
    step();
    csr_we = 1'b0;
    csr_op = CSR_NONE;
  endtask
`ifdef CSR_COUNTER_EN
  logic [31:0] base;
`endif
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    INT = 1'b0;
    inst_valid = 1'b1;
    ecall = 1'b1;
    mret = 1'b0;
    illegal_inst = 1'b0;
    csr_we = 1'b0;
    csr_op = CSR_NONE;
    csr_addr = CSR_MTVEC;
    csr_wdata = '0;
    pc_cur = '0;
    pc_next = '0;
    repeat (2) step();
    check("rst_redirect", redirect, 0);
    check("rst_pend", int_pend, 0);
    rst = 1'b0;
    ecall = 1'b0;
    chk_csr("rst_mstatus", CSR_MSTATUS, 0);
    chk_csr("rst_mtvec", CSR_MTVEC, 0);
    chk_csr("rst_mcause", CSR_MCAUSE, 0);
    wr(CSR_RW, CSR_MSTATUS, 32'hFFFF_FFFF);
    chk_csr("mstatus_mask", CSR_MSTATUS, 32'h88);
    wr(CSR_RW, CSR_MTVEC, 32'h101);
    chk_csr("mtvec_rw", CSR_MTVEC, 32'h101);
    ecall = 1'b1;
    pc_cur = 32'h40;
    pc_next = 32'h44;
    #1;
    check("ecall_redirect", redirect, 1);
    check("ecall_target", redirect_pc, 32'h100);
    step();
    ecall = 1'b0;
    chk_csr("ecall_mepc", CSR_MEPC, 32'h40);
    chk_csr("ecall_mcause", CSR_MCAUSE, 11);
    chk_csr("ecall_mstatus", CSR_MSTATUS, 32'h80);
    inst_valid = 1'b0;
    ecall = 1'b1;
    pc_cur = 32'h60;
    #1;
    check("stall_redirect", redirect, 0);
    step();
    ecall = 1'b0;
    inst_valid = 1'b1;
    chk_csr("stall_mepc", CSR_MEPC, 32'h40);
    chk_csr("stall_mstatus", CSR_MSTATUS, 32'h80);
    wr(CSR_RS, CSR_MSCRATCH, 32'h0F);
    chk_csr("rs_mscratch", CSR_MSCRATCH, 32'h0F);
    wr(CSR_RC, CSR_MSCRATCH, 32'h03);
    chk_csr("rc_mscratch", CSR_MSCRATCH, 32'h0C);
    wr(CSR_RW, 12'h123, 32'hFFFF_FFFF);
    chk_csr("unimpl_read", 12'h123, 0);
    wr(CSR_NONE, CSR_MSCRATCH, 32'hFFFF_FFFF);
    chk_csr("op_none", CSR_MSCRATCH, 32'h0C);
`ifndef CSR_COUNTER_EN
    wr(CSR_RW, CSR_MCYCLE, 32'h5);
    chk_csr("no_mcycle", CSR_MCYCLE, 0);
    chk_csr("no_minstret", CSR_MINSTRET, 0);
`endif
    illegal_inst = 1'b1;
    ecall = 1'b1;
    pc_cur = 32'h20;
    csr_we = 1'b1;
    csr_op = CSR_RW;
    csr_addr = CSR_MSCRATCH;
    csr_wdata = 32'hDEAD;
    #1;
    check("illegal_target", redirect_pc, 32'h100);
    step();
    illegal_inst = 1'b0;
    ecall = 1'b0;
    csr_we = 1'b0;
    csr_op = CSR_NONE;
    chk_csr("illegal_mcause", CSR_MCAUSE, 2);
    chk_csr("illegal_mepc", CSR_MEPC, 32'h20);
    chk_csr("illegal_nowrite", CSR_MSCRATCH, 32'h0C);
    chk_csr("illegal_mstatus", CSR_MSTATUS, 0);
    wr(CSR_RW, CSR_MSTATUS, 32'h8);
    wr(CSR_RW, CSR_MIE, 32'hFFFF_FFFF);
    chk_csr("mie_mask", CSR_MIE, 32'h800);
    inst_valid = 1'b0;
    INT = 1'b1;
    step();
    check("int_e0", int_pend, 0);
    step();
    check("int_e1", int_pend, 0);
    step();
    check("int_e2", int_pend, 1);
    INT = 1'b0;
    inst_valid = 1'b1;
    pc_cur = 32'h80;
    pc_next = 32'h84;
    #1;
    check("int_redirect", redirect, 1);
    check("int_target", redirect_pc, 32'h100);
    step();
    chk_csr("int_mcause", CSR_MCAUSE, MCAUSE_MEI);
    chk_csr("int_mepc", CSR_MEPC, 32'h84);
    check("int_clear", int_pend, 0);
    chk_csr("int_mstatus", CSR_MSTATUS, 32'h80);
    wr(CSR_RW, CSR_MEPC, 32'h87);
    chk_csr("mepc_mask", CSR_MEPC, 32'h84);
    mret = 1'b1;
    #1;
    check("mret_redirect", redirect, 1);
    check("mret_target", redirect_pc, 32'h84);
    step();
    mret = 1'b0;
    chk_csr("mret_mstatus", CSR_MSTATUS, 32'h88);
    inst_valid = 1'b0;
    INT = 1'b1;
    repeat (3) step();
    INT = 1'b0;
    repeat (4) step();
    check("pend_hold_stall", int_pend, 1);
    INT = 1'b1;
    repeat (2) step();
    inst_valid = 1'b1;
    pc_next = 32'h300;
    #1;
    check("setclr_redirect", redirect, 1);
    step();
    INT = 1'b0;
    check("set_wins", int_pend, 1);
    chk_csr("setclr_mepc", CSR_MEPC, 32'h300);
    chk_csr("setclr_mstatus", CSR_MSTATUS, 32'h80);
    pc_next = 32'h200;
    #1;
    check("masked_redirect", redirect, 0);
    step();
    check("masked_pend", int_pend, 1);
    csr_we = 1'b1;
    csr_op = CSR_RS;
    csr_addr = CSR_MSTATUS;
    csr_wdata = 32'h8;
    #1;
    check("enable_cycle", redirect, 0);
    step();
    csr_we = 1'b0;
    csr_op = CSR_NONE;
    #1;
    check("enabled_redirect", redirect, 1);
    step();
    chk_csr("enabled_mepc", CSR_MEPC, 32'h200);
    check("enabled_clear", int_pend, 0);
`ifdef CSR_COUNTER_EN
    csr_addr = CSR_MCYCLE;
    #1;
    base = csr_rdata;
    repeat (10) step();
    chk_csr("mcycle_ten", CSR_MCYCLE, base + 32'd10);
    wr(CSR_RW, CSR_MCYCLE, 32'h1234);
    chk_csr("mcycle_write", CSR_MCYCLE, 32'h1234);
    csr_addr = CSR_MINSTRET;
    #1;
    base = csr_rdata;
    step();
    chk_csr("minstret_inc", CSR_MINSTRET, base + 32'd1);
    inst_valid = 1'b0;
    step();
    inst_valid = 1'b1;
    chk_csr("minstret_stall", CSR_MINSTRET, base + 32'd1);
`endif
    ecall = 1'b1;
    pc_cur = 32'h500;
    #1;
    check("pre_rst_redirect", redirect, 1);
    rst = 1'b1;
    #1;
    check("midtrap_redirect", redirect, 0);
    chk_csr("midtrap_mtvec", CSR_MTVEC, 0);
    check("midtrap_pend", int_pend, 0);
    step();
    ecall = 1'b0;
    rst = 1'b0;
    step();
    chk_csr("post_rst_mepc", CSR_MEPC, 0);
    chk_csr("post_rst_mcause", CSR_MCAUSE, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
